thirty_two_bit_accumulator: RTL and testbench

//   Sequential stage downstream of the 32-bit full adder. Accepts a burst of
//   32-bit operands over a valid/ready stream, sums them into a running total
//   via one adder instance, and presents the final sum plus a sticky carry

---
 rtl/thirty_two_bit_accumulator_pkg.sv | 23 ++
 rtl/thirty_two_bit_accumulator_if.sv | 42 ++++
 rtl/thirty_two_bit_accumulator_acc_adder.sv | 36 +++
 rtl/thirty_two_bit_accumulator.sv | 130 +++++++++++++
 tb/tb_thirty_two_bit_accumulator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/thirty_two_bit_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// thirty_two_bit_acc_pkg
//   Shared definitions for the thirty_two_bit_accumulator slice:
//     - state_t      : accumulator FSM states (IDLE, ACCUM, DONE)
//     - DEF_WIDTH    : default operand/sum width
//     - DEF_LEN_W    : default burst-length field width
//     - SAT_ONES     : all-ones value an accumulator clamps to on saturation
//   Optional feature macro used by the slice: SATURATE_EN.
// ----------------------------------------------------------------------------
package thirty_two_bit_acc_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_LEN_W = 8;

    localparam logic [DEF_WIDTH-1:0] SAT_ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : thirty_two_bit_acc_pkg

// File: rtl/thirty_two_bit_accumulator_if.sv
// ----------------------------------------------------------------------------
// thirty_two_bit_accumulator_if
//   Operand stream, result stream and burst control of the accumulator.
//   Ports carried:
//     start, len              burst request (producer -> accumulator)
//     in_valid, in_data       operand stream (producer -> accumulator)
//     in_ready                operand backpressure (accumulator -> producer)
//     out_valid, out_sum,
//     out_carry               result stream (accumulator -> consumer)
//     out_ready               result backpressure (consumer -> accumulator)
//     busy                    accumulator not in IDLE
//   Modports: master = producer/consumer side, slave = accumulator side.
// ----------------------------------------------------------------------------
interface thirty_two_bit_accumulator_if
    import thirty_two_bit_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W
);

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, busy
    );

endinterface : thirty_two_bit_accumulator_if

// File: rtl/thirty_two_bit_accumulator_acc_adder.sv
// ----------------------------------------------------------------------------
// acc_adder
//   Combinational WIDTH-bit ripple-carry adder.
//   Ports:
//     a, b   in   WIDTH  operands
//     cin    in   1      carry-in
//     sum    out  WIDTH  a + b + cin (modulo 2**WIDTH)
//     cout   out  1      carry-out of the top bit
// ----------------------------------------------------------------------------
module acc_adder
    import thirty_two_bit_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Ripple carry held in a single scalar walked LSB to MSB so the chain
    // is not a self-referencing vector.
    logic ripple;

    always_comb begin
        ripple = cin;
        sum    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ ripple;
            ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
        end
        cout = ripple;
    end

endmodule : acc_adder

// File: rtl/thirty_two_bit_accumulator.sv
// ----------------------------------------------------------------------------
// thirty_two_bit_accumulator
//   Sums a burst of operands arriving over a valid/ready stream into a
//   running total and presents the final sum plus a sticky carry flag on a
//   valid/ready result port.
//   Ports:
//     clk      in   1      rising-edge clock
//     rst_n    in   1      asynchronous active-low reset
//     bus      slave modport of thirty_two_bit_accumulator_if
//                (start/len, in_valid/in_ready/in_data,
//                 out_valid/out_ready/out_sum/out_carry, busy)
//   Configuration macro:
//     SATURATE_EN  defined   : on carry-out the total clamps to all-ones for
//                              the rest of the burst; out_carry flags it.
//                  undefined : total wraps modulo 2**WIDTH; out_carry is the
//                              sticky OR of every carry-out in the burst.
// ----------------------------------------------------------------------------
module thirty_two_bit_accumulator
    import thirty_two_bit_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    thirty_two_bit_accumulator_if.slave bus
);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [LEN_W-1:0] remaining_q;
    logic             carry_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             beat;

    acc_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q),
        .b    (bus.in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // in_ready_q is only ever high in ACCUM, so this is the beat strobe.
    assign beat = bus.in_valid & in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q       <= '0;
                        carry_q     <= 1'b0;
                        remaining_q <= bus.len;
                        busy_q      <= 1'b1;
                        if (bus.len != '0) begin
                            state_q    <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            // Empty burst: report a zero result straight away.
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end

                ACCUM: begin
                    if (beat) begin
`ifdef SATURATE_EN
                        // Once clamped, further operands cannot move the total.
                        if (add_cout || carry_q) begin
                            acc_q <= '1;
                        end else begin
                            acc_q <= add_sum;
                        end
`else
                        acc_q <= add_sum;
`endif
                        carry_q     <= carry_q | add_cout;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately ignored here, even on the ack
                    // cycle: a new burst always needs an IDLE cycle.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_carry = carry_q;
    assign bus.busy      = busy_q;

endmodule : thirty_two_bit_accumulator

// File: tb/tb_thirty_two_bit_accumulator.sv
// ----------------------------------------------------------------------------
// tb_thirty_two_bit_accumulator
//   Bench for thirty_two_bit_accumulator. Honours SATURATE_EN when choosing
//   expected results.
// ----------------------------------------------------------------------------
module tb_thirty_two_bit_accumulator;

    logic clk;
    logic rst_n;

    thirty_two_bit_accumulator_if #(.WIDTH(32), .LEN_W(8)) bus ();

    thirty_two_bit_accumulator #(
        .WIDTH (32),
        .LEN_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              len;
        logic [3:0][31:0] data;
        logic [31:0]     wrap_sum;
        logic            wrap_carry;
        logic [31:0]     sat_sum;
        logic            sat_carry;
        bit              toggle;
        int              hold;
        bit              ack_start;
    } vec_t;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] ws, input logic wc,
                                input logic [31:0] ss, input logic sc,
                                input bit tog, input int hold, input bit acks);
        vec_t v;
        v.len        = len;
        v.data[0]    = d0;
        v.data[1]    = d1;
        v.data[2]    = d2;
        v.data[3]    = d3;
        v.wrap_sum   = ws;
        v.wrap_carry = wc;
        v.sat_sum    = ss;
        v.sat_carry  = sc;
        v.toggle     = tog;
        v.hold       = hold;
        v.ack_start  = acks;
        return v;
    endfunction

    function automatic exp_t expected(input vec_t v);
        exp_t e;
`ifdef SATURATE_EN
        e.sum   = v.sat_sum;
        e.carry = v.sat_carry;
`else
        e.sum   = v.wrap_sum;
        e.carry = v.wrap_carry;
`endif
        return e;
    endfunction

    // Result monitor: sampled 2 time units after the falling edge, after any
    // input changes the stimulus makes at +1.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 33'd1, 33'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_sum", {1'b0, bus.out_sum}, {1'b0, e.sum});
                    check("result_carry", {32'd0, bus.out_carry}, {32'd0, e.carry});
                end
            end
        end
    end

    task automatic run_burst(input vec_t v, input string nm);
        int got = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        bit acc_beat;
        exp_t e;
        e = expected(v);

        @(negedge clk);
        #1;
        bus.start     = 1'b1;
        bus.len       = 8'(v.len);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        check({nm, "_busy_after_start"}, {32'd0, bus.busy}, 33'd1);
        check({nm, "_in_ready_after_start"}, {32'd0, bus.in_ready}, {32'd0, v.len != 0});

        while (got < v.len && cyc < 64) begin
            if (v.toggle && !ph) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 32'hDEAD_BEEF;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = v.data[got];
            end
            ph = !ph;
            // A start pulse mid-burst must not re-latch len.
            bus.start = (cyc == 1);
            bus.len   = 8'd1;
            #1;
            acc_beat = bus.in_valid && bus.in_ready;
            @(negedge clk);
            #1;
            if (acc_beat) got++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({nm, "_beats_accepted"}, 33'(got), 33'(v.len));

        // Result must be valid on the cycle after the final beat.
        check({nm, "_out_valid_latency"}, {32'd0, bus.out_valid}, 33'd1);
        check({nm, "_in_ready_in_done"}, {32'd0, bus.in_ready}, 33'd0);

        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            #1;
            check({nm, "_hold_valid"}, {32'd0, bus.out_valid}, 33'd1);
            check({nm, "_hold_sum"}, {1'b0, bus.out_sum}, {1'b0, e.sum});
        end

        bus.out_ready = 1'b1;
        if (v.ack_start) begin
            bus.start = 1'b1;
            bus.len   = 8'd3;
        end
        @(negedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check({nm, "_out_valid_dropped"}, {32'd0, bus.out_valid}, 33'd0);
        check({nm, "_idle_after_ack"}, {32'd0, bus.busy}, 33'd0);
        if (v.ack_start) begin
            @(negedge clk);
            #1;
            check({nm, "_ack_start_ignored"}, {31'd0, bus.busy, bus.in_ready}, 33'd0);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        vecs.push_back(mk(2, 32'd13, 32'd2, 0, 0, 32'd15, 0, 32'd15, 0, 0, 0, 0));
        vecs.push_back(mk(3, 32'h0800_010D, 32'h1700_0002, 32'h0000_000D, 0,
                          32'h1F00_011C, 0, 32'h1F00_011C, 0, 0, 0, 0));
        vecs.push_back(mk(2, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0,
                          32'h0000_0001, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0));
        vecs.push_back(mk(4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 0, 32'd10, 0, 1, 5, 0));
        vecs.push_back(mk(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                          32'hFFFF_FFFC, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
        vecs.push_back(mk(3, 32'h8000_0000, 32'h8000_0000, 32'd5, 0,
                          32'd5, 1, 32'hFFFF_FFFF, 1, 0, 0, 1));

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", {32'd0, bus.out_valid}, 33'd0);
        check("reset_in_ready", {32'd0, bus.in_ready}, 33'd0);
        check("reset_busy", {32'd0, bus.busy}, 33'd0);
        check("reset_out_sum", {1'b0, bus.out_sum}, 33'd0);
        check("reset_out_carry", {32'd0, bus.out_carry}, 33'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a 4-beat burst.
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.len   = 8'd4;
        @(negedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd100;
        @(negedge clk);
        #1;
        bus.in_data = 32'd200;
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("midburst_partial_sum", {1'b0, bus.out_sum}, 33'd300);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {32'd0, bus.busy}, 33'd0);
        check("abort_in_ready", {32'd0, bus.in_ready}, 33'd0);
        check("abort_out_valid", {32'd0, bus.out_valid}, 33'd0);
        check("abort_out_sum", {1'b0, bus.out_sum}, 33'd0);
        check("abort_out_carry", {32'd0, bus.out_carry}, 33'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_burst(mk(1, 32'd7, 0, 0, 0, 32'd7, 0, 32'd7, 0, 0, 0, 0), "post_reset");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 33'(sb.size()), 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_thirty_two_bit_accumulator
